// File: rtl/axi4_sp_pkg.sv
// Shared encodings, FSM state type and burst-length helper for the AXI4
// single-port memory controller.
package axi4_sp_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_RESP,
    RD_REQ,
    RD_DATA
  } state_e;

  // WRAP bursts must span 2, 4, 8 or 16 beats
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/sp_ram_bytewe.sv
// Single-port RAM with per-byte write enables and a registered read port;
// read data holds its last value while no read is issued.
module sp_ram_bytewe #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            re,
  input  logic [DW/8-1:0] we,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);

  logic [DW/8-1:0][7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[addr];
    for (int b = 0; b < DW/8; b++) begin
      if (we[b]) mem[addr][b] <= wdata[b*8 +: 8];
    end
  end

endmodule

// File: rtl/axi4_sp_mem_ctrl.sv
// AXI4 slave sharing one single-port byte-writable RAM between the write and
// read channels; whole bursts are serialised with a round-robin grant.
module axi4_sp_mem_ctrl
  import axi4_sp_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int MEM_AW     = 10
) (
  input  logic                    io_systemClk,
  input  logic                    io_systemReset,
  input  logic [ID_WIDTH-1:0]     axi_awid,
  input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [7:0]              axi_awlen,
  input  logic [2:0]              axi_awsize,
  input  logic [1:0]              axi_awburst,
  input  logic                    axi_awlock,
  input  logic [3:0]              axi_awcache,
  input  logic [2:0]              axi_awprot,
  input  logic [3:0]              axi_awqos,
  input  logic [3:0]              axi_awregion,
  input  logic                    axi_awvalid,
  output logic                    axi_awready,
  input  logic [DATA_WIDTH-1:0]   axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                    axi_wlast,
  input  logic                    axi_wvalid,
  output logic                    axi_wready,
  output logic [ID_WIDTH-1:0]     axi_bid,
  output logic [1:0]              axi_bresp,
  output logic                    axi_bvalid,
  input  logic                    axi_bready,
  input  logic [ID_WIDTH-1:0]     axi_arid,
  input  logic [ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [7:0]              axi_arlen,
  input  logic [2:0]              axi_arsize,
  input  logic [1:0]              axi_arburst,
  input  logic                    axi_arlock,
  input  logic [3:0]              axi_arcache,
  input  logic [2:0]              axi_arprot,
  input  logic [3:0]              axi_arqos,
  input  logic [3:0]              axi_arregion,
  input  logic                    axi_arvalid,
  output logic                    axi_arready,
  output logic [ID_WIDTH-1:0]     axi_rid,
  output logic [DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]              axi_rresp,
  output logic                    axi_rlast,
  output logic                    axi_rvalid,
  input  logic                    axi_rready,
  output logic                    axi_interrupt
);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } areq_t;

  state_e              state_q, state_d;
  logic                last_was_rd_q, last_was_rd_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [MEM_AW-1:0]   ptr_q, ptr_d, ptr_nxt;
  logic [1:0]          burst_q, burst_d;
  logic [3:0]          wmask_q, wmask_d;
  logic                err_q, err_d;

  areq_t               a_req;
  logic                pick_rd;
  logic                wr_err;
  logic                ram_re;
  logic [DATA_WIDTH/8-1:0] ram_we;
  logic [DATA_WIDTH-1:0]   ram_q;

  // Read wins when it is alone, or when both are pending and write went last
  assign pick_rd = axi_arvalid && !(axi_awvalid && last_was_rd_q);
  assign a_req   = pick_rd ? areq_t'{axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst}
                           : areq_t'{axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst};

  always_comb begin
    ptr_nxt = ptr_q + MEM_AW'(1);
    if (burst_q == BURST_FIXED)
      ptr_nxt = ptr_q;
    else if (burst_q == BURST_WRAP)
      ptr_nxt = (ptr_q & ~MEM_AW'(wmask_q)) | ((ptr_q + MEM_AW'(1)) & MEM_AW'(wmask_q));
  end

  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) begin
      state_q       <= IDLE;
      last_was_rd_q <= 1'b1;
      id_q          <= '0;
      cnt_q         <= '0;
      ptr_q         <= '0;
      burst_q       <= BURST_INCR;
      wmask_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_was_rd_q <= last_was_rd_d;
      id_q          <= id_d;
      cnt_q         <= cnt_d;
      ptr_q         <= ptr_d;
      burst_q       <= burst_d;
      wmask_q       <= wmask_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_was_rd_d = last_was_rd_q;
    id_d          = id_q;
    cnt_d         = cnt_q;
    ptr_d         = ptr_q;
    burst_d       = burst_q;
    wmask_d       = wmask_q;
    err_d         = err_q;
    wr_err        = 1'b0;
    axi_awready   = 1'b0;
    axi_arready   = 1'b0;
    axi_wready    = 1'b0;
    axi_bvalid    = 1'b0;
    axi_rvalid    = 1'b0;
    ram_re        = 1'b0;
    ram_we        = '0;
    case (state_q)
      IDLE: begin
        if (axi_awvalid || axi_arvalid) begin
          axi_awready = !pick_rd;
          axi_arready = pick_rd;
          id_d        = a_req.id;
          cnt_d       = a_req.len;
          ptr_d       = a_req.addr[MEM_AW+1:2];
          burst_d     = a_req.burst;
          wmask_d     = a_req.len[3:0];
          err_d       = (a_req.size != 3'b010) || (a_req.burst == 2'b11) ||
                        ((a_req.burst == BURST_WRAP) && !wrap_len_ok(a_req.len));
          state_d     = pick_rd ? RD_REQ : WR_DATA;
        end
      end
      WR_DATA: begin
        axi_wready = 1'b1;
        if (axi_wvalid) begin
          // the counter, not wlast, decides where the burst ends
          wr_err = err_q || (axi_wlast != (cnt_q == 8'd0));
          err_d  = wr_err;
          if (!wr_err) ram_we = axi_wstrb;
          if (cnt_q == 8'd0) begin
            state_d = WR_RESP;
          end else begin
            cnt_d = cnt_q - 8'd1;
            ptr_d = ptr_nxt;
          end
        end
      end
      WR_RESP: begin
        axi_bvalid = 1'b1;
        if (axi_bready) begin
          state_d       = IDLE;
          last_was_rd_d = 1'b0;
        end
      end
      RD_REQ: begin
        ram_re  = 1'b1;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        axi_rvalid = 1'b1;
        if (axi_rready) begin
          if (cnt_q == 8'd0) begin
            state_d       = IDLE;
            last_was_rd_d = 1'b1;
          end else begin
            cnt_d   = cnt_q - 8'd1;
            ptr_d   = ptr_nxt;
            state_d = RD_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign axi_bid       = id_q;
  assign axi_rid       = id_q;
  assign axi_bresp     = (state_q == WR_RESP && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign axi_rresp     = (state_q == RD_DATA && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign axi_rdata     = (state_q == RD_DATA && !err_q) ? ram_q : '0;
  assign axi_rlast     = (state_q == RD_DATA) && (cnt_q == 8'd0);
  assign axi_interrupt = err_q && ((axi_bvalid && axi_bready) || (axi_rvalid && axi_rready));

  sp_ram_bytewe #(.AW(MEM_AW), .DW(DATA_WIDTH)) u_ram (
    .clk   (io_systemClk),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (ptr_q),
    .wdata (axi_wdata),
    .rdata (ram_q)
  );

  logic unused_sigs;
  assign unused_sigs = ^{a_req.addr[ADDR_WIDTH-1:MEM_AW+2], a_req.addr[1:0],
                         axi_awlock, axi_awcache, axi_awprot, axi_awqos, axi_awregion,
                         axi_arlock, axi_arcache, axi_arprot, axi_arqos, axi_arregion};

endmodule

// File: tb/tb_axi4_sp_mem_ctrl.sv
// Randomised scoreboard bench for axi4_sp_mem_ctrl: a word-level memory model
// predicts B/R responses, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_axi4_sp_mem_ctrl;
  localparam int DEPTH   = 1024;
  localparam int B_FIXED = 0, B_INCR = 1, B_WRAP = 2;

  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  axi_awid, axi_arid, axi_bid, axi_rid;
  logic [31:0] axi_awaddr, axi_araddr, axi_wdata, axi_rdata;
  logic [7:0]  axi_awlen, axi_arlen;
  logic [2:0]  axi_awsize, axi_arsize;
  logic [1:0]  axi_awburst, axi_arburst, axi_bresp, axi_rresp;
  logic        axi_awvalid, axi_awready, axi_arvalid, axi_arready;
  logic [3:0]  axi_wstrb;
  logic        axi_wlast, axi_wvalid, axi_wready;
  logic        axi_bvalid, axi_bready, axi_rlast, axi_rvalid, axi_rready, axi_interrupt;

  always #5 clk = ~clk;

  axi4_sp_mem_ctrl dut (
    .io_systemClk(clk), .io_systemReset(rst),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awlock(1'b0),
    .axi_awcache(4'h0), .axi_awprot(3'h0), .axi_awqos(4'h0), .axi_awregion(4'h0),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(1'b0),
    .axi_arcache(4'h0), .axi_arprot(3'h0), .axi_arqos(4'h0), .axi_arregion(4'h0),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_interrupt(axi_interrupt)
  );

  typedef struct { int id; int resp; } bexp_t;
  typedef struct { int id; logic [31:0] data; logic [31:0] mask; int resp; bit last; } rexp_t;

  bexp_t       bq[$];
  rexp_t       rq[$];
  int          glog[$];
  logic [31:0] mdl [DEPTH];
  logic [3:0]  kb  [DEPTH];
  logic [31:0] wd  [16];
  logic [3:0]  ws  [16];
  int          n_chk = 0, n_pass = 0;
  bit          rdy_auto = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic bit addr_err(input int size, input int burst, input int len);
    return size != 2 || burst == 3 ||
           (burst == B_WRAP && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  // word visited by beat i, straight from the burst rules
  function automatic int beat_word(input int st, input int len, input int burst, input int i);
    int n, base;
    if (burst == B_FIXED) return st;
    if (burst == B_WRAP) begin
      n    = len + 1;
      base = (st / n) * n;
      return base + (st - base + i) % n;
    end
    return (st + i) % DEPTH;
  endfunction

  function automatic logic [31:0] bmask(input logic [3:0] k);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{k[b]}};
    return m;
  endfunction

  task automatic wait_hs(input int ch, input string name);
    int n;
    bit hs;
    n  = 0;
    hs = 1'b0;
    while (!hs && n < 500) begin
      @(negedge clk);
      case (ch)
        0:       hs = axi_awready;
        1:       hs = axi_wready;
        default: hs = axi_arready;
      endcase
      n++;
    end
    chk(name, hs, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input int id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input int bad);
    bit aerr;
    int st, w;
    aerr = addr_err(size, burst, len);
    st   = int'(addr[11:2]);
    for (int i = 0; i <= len; i++) begin
      w = beat_word(st, len, burst, i);
      if (aerr || (bad >= 0 && i > bad)) continue;
      if (i == bad) begin
        kb[w] = kb[w] & ~ws[i];
        continue;
      end
      for (int b = 0; b < 4; b++)
        if (ws[i][b]) mdl[w][b*8 +: 8] = wd[i][b*8 +: 8];
      kb[w] = kb[w] | ws[i];
    end
    bq.push_back('{id, (aerr || bad >= 0) ? 2 : 0});
    axi_awid = 8'(id); axi_awaddr = addr; axi_awlen = 8'(len);
    axi_awsize = 3'(size); axi_awburst = 2'(burst); axi_awvalid = 1'b1;
    wait_hs(0, "aw_handshake");
    axi_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      axi_wdata = wd[i]; axi_wstrb = ws[i];
      axi_wlast = (i == len) ^ (i == bad);
      axi_wvalid = 1'b1;
      wait_hs(1, "w_handshake");
      axi_wvalid = 1'b0; axi_wlast = 1'b0;
    end
  endtask

  task automatic do_read(input int id, input logic [31:0] addr, input int len,
                         input int size, input int burst);
    bit aerr;
    int st, w;
    aerr = addr_err(size, burst, len);
    st   = int'(addr[11:2]);
    for (int i = 0; i <= len; i++) begin
      w = beat_word(st, len, burst, i);
      rq.push_back('{id, aerr ? 32'h0 : mdl[w], aerr ? 32'hFFFF_FFFF : bmask(kb[w]),
                     aerr ? 2 : 0, i == len});
    end
    axi_arid = 8'(id); axi_araddr = addr; axi_arlen = 8'(len);
    axi_arsize = 3'(size); axi_arburst = 2'(burst); axi_arvalid = 1'b1;
    wait_hs(2, "ar_handshake");
    axi_arvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 3000) begin @(posedge clk); n++; end
    chk("drain_b_queue", bq.size(), 0);
    chk("drain_r_queue", rq.size(), 0);
    @(posedge clk); #1;
  endtask

  // monitor: compare every completed B/R handshake against the scoreboard
  always @(negedge clk) begin : mon
    bexp_t be;
    rexp_t re;
    bit    hs;
    if (!rst) begin
      hs = 1'b0;
      if (axi_awvalid && axi_awready) glog.push_back(0);
      if (axi_arvalid && axi_arready) glog.push_back(1);
      if (axi_bvalid && axi_bready) begin
        hs = 1'b1;
        if (bq.size() == 0) chk("b_unexpected", bq.size(), 1);
        else begin
          be = bq.pop_front();
          chk("bid", axi_bid, be.id);
          chk("bresp", axi_bresp, be.resp);
          chk("b_interrupt", axi_interrupt, be.resp == 2);
        end
      end
      if (axi_rvalid && axi_rready) begin
        hs = 1'b1;
        if (rq.size() == 0) chk("r_unexpected", rq.size(), 1);
        else begin
          re = rq.pop_front();
          chk("rid", axi_rid, re.id);
          chk("rresp", axi_rresp, re.resp);
          chk("rlast", axi_rlast, re.last);
          chk("rdata", axi_rdata & re.mask, re.data & re.mask);
          chk("r_interrupt", axi_interrupt, re.resp == 2);
        end
      end
      if (!hs) chk("idle_interrupt", axi_interrupt, 0);
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rdy_auto) begin
      axi_bready = ($urandom % 4) != 0;
      axi_rready = ($urandom % 4) != 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len, burst, size, bad, word, n;
    logic [31:0] addr;
    axi_awvalid = 0; axi_arvalid = 0; axi_wvalid = 0; axi_wlast = 0;
    axi_bready = 0; axi_rready = 0; axi_wdata = 0; axi_wstrb = 0;
    axi_awid = 0; axi_awaddr = 0; axi_awlen = 0; axi_awsize = 0; axi_awburst = 0;
    axi_arid = 0; axi_araddr = 0; axi_arlen = 0; axi_arsize = 0; axi_arburst = 0;
    for (int i = 0; i < DEPTH; i++) begin mdl[i] = '0; kb[i] = '0; end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", axi_awready, 0); chk("rst_arready", axi_arready, 0);
    chk("rst_wready", axi_wready, 0);   chk("rst_bvalid", axi_bvalid, 0);
    chk("rst_rvalid", axi_rvalid, 0);   chk("rst_bresp", axi_bresp, 0);
    chk("rst_rresp", axi_rresp, 0);     chk("rst_rdata", axi_rdata, 0);
    chk("rst_rlast", axi_rlast, 0);     chk("rst_bid", axi_bid, 0);
    chk("rst_rid", axi_rid, 0);         chk("rst_interrupt", axi_interrupt, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // contention straight out of reset: expect W, R, W, R
    glog.delete();
    for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    fork
      begin do_write(1, 32'h200, 1, 2, B_INCR, -1); do_write(3, 32'h210, 0, 2, B_INCR, -1); end
      begin do_read(2, 32'h300, 1, 2, B_INCR);      do_read(4, 32'h310, 0, 2, B_INCR); end
    join
    drain();
    chk("grant_count", glog.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("grant_order_%0d", i), (glog.size() > i) ? glog[i] : 9, i % 2);

    for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + i;
    do_write(5, 32'h10, 3, 2, B_INCR, -1);
    do_read(6, 32'h10, 3, 2, B_INCR);

    wd[0] = 32'h1122_3344; ws[0] = 4'hF;
    do_write(7, 32'h0, 0, 2, B_INCR, -1);
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'h2;
    do_write(7, 32'h0, 0, 2, B_INCR, -1);
    ws[0] = 4'hF;
    do_read(8, 32'h0, 0, 2, B_INCR);

    for (int i = 0; i < 4; i++) wd[i] = 32'hC0 + i;
    do_write(11, 32'h30, 3, 2, B_INCR, -1);
    do_read(12, 32'h38, 3, 2, B_WRAP);

    wd[0] = 32'hDEAD_BEEF;
    do_write(13, 32'h10, 0, 1, B_INCR, -1);
    do_read(14, 32'h10, 0, 2, B_INCR);

    for (int i = 0; i < 4; i++) wd[i] = 32'h5000 + i;
    do_write(15, 32'h80, 3, 2, B_INCR, -1);
    for (int i = 0; i < 4; i++) wd[i] = 32'h7700 + i;
    do_write(16, 32'h80, 3, 2, B_INCR, 1);
    do_read(17, 32'h80, 3, 2, B_INCR);
    do_read(18, 32'h10, 1, 2, 3);

    for (int i = 0; i < 3; i++) wd[i] = 32'h9900 + i;
    do_write(19, 32'h40, 2, 2, B_FIXED, -1);
    do_read(20, 32'h40, 1, 2, B_FIXED);
    drain();

    for (int t = 0; t < 60; t++) begin
      n = $urandom % 10;
      burst = (n < 2) ? B_FIXED : (n < 6) ? B_INCR : (n < 9) ? B_WRAP : 3;
      if (burst == B_WRAP && ($urandom % 5) != 0) len = (2 << ($urandom % 4)) - 1;
      else len = $urandom % 16;
      size = (($urandom % 10) == 0) ? int'($urandom % 8) : 2;
      word = (($urandom % 4) == 0) ? 1008 + int'($urandom % 16) : int'($urandom % 64);
      addr = $urandom;
      addr[11:2] = 10'(word);
      addr[1:0]  = 2'b00;
      if ($urandom % 2) begin
        for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        bad = (($urandom % 8) == 0) ? int'($urandom % (len + 1)) : -1;
        do_write(t, addr, len, size, burst, bad);
      end else begin
        do_read(t, addr, len, size, burst);
      end
    end
    drain();

    // reset in the middle of a read burst
    for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(30, 32'h100, 7, 2, B_INCR, -1);
    drain();
    rdy_auto = 1'b0;
    @(posedge clk); #1;
    axi_rready = 1'b0; axi_bready = 1'b0;
    do_read(31, 32'h100, 7, 2, B_INCR);
    n = 0;
    do begin @(negedge clk); n++; end while (!axi_rvalid && n < 100);
    chk("mid_rst_beat1_valid", axi_rvalid, 1);
    @(posedge clk); #1; axi_rready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1; axi_rready = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_beat2_valid", axi_rvalid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_rvalid", axi_rvalid, 0);
    chk("mid_rst_rlast", axi_rlast, 0);
    chk("mid_rst_rid", axi_rid, 0);
    chk("mid_rst_bvalid", axi_bvalid, 0);
    chk("mid_rst_interrupt", axi_interrupt, 0);
    chk("mid_rst_beats_left", rq.size(), 7);
    rq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_auto = 1'b1;
    do_read(32, 32'h100, 7, 2, B_INCR);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
